// File: rtl/tnoc_flit_receiver.sv
// tnoc_flit_receiver: flit input buffer for a NoC router port.
// Holds flits in a first-word-fall-through FIFO and counts the packets
// that complete.
// The optional framing checker (macro TNOC_FLIT_RECEIVER_CHECKER_EN)
// tracks packet boundaries and raises a sticky framing_error flag.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Ready never depends on the same-side valid. flit_out_* stays
// stable while valid=1 and ready=0.
module tnoc_flit_receiver #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flit_in_valid,
  output logic                  flit_in_ready,
  input  logic                  flit_in_type,
  input  logic                  flit_in_head,
  input  logic                  flit_in_tail,
  input  logic [DATA_WIDTH-1:0] flit_in_data,
  output logic                  flit_in_vc_available,
  output logic                  flit_out_valid,
  input  logic                  flit_out_ready,
  output logic                  flit_out_type,
  output logic                  flit_out_head,
  output logic                  flit_out_tail,
  output logic [DATA_WIDTH-1:0] flit_out_data,
  output logic [15:0]           packet_count,
  output logic                  framing_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Each entry is stored as {type, head, tail, data}.
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            vc_avail_q, vc_avail_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic            push, pop;
  logic [EW-1:0]   head_entry;

  // Ready is derived from stored occupancy only, so a pop on a full
  // FIFO does not open a slot in the same cycle. It is held low while
  // reset is asserted.
  assign flit_in_ready        = ~rst & (count_q != DEPTH_C);
  assign flit_out_valid       = (count_q != '0);
  assign push                 = flit_in_valid & flit_in_ready;
  assign pop                  = flit_out_valid & flit_out_ready;
  assign flit_in_vc_available = vc_avail_q;
  assign packet_count         = pkt_cnt_q;
  assign head_entry           = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy, vc availability and the packet counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && flit_in_tail) pkt_cnt_d = pkt_cnt_q + 16'd1;
    vc_avail_d = ((DEPTH_C - count_d) >= CW'(2));
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vc_avail_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vc_avail_q <= vc_avail_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // FIFO storage. Entries are not reset; the outputs are masked when the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {flit_in_type, flit_in_head, flit_in_tail, flit_in_data};
  end

  // First-word fall-through view of the head entry. It reads zero when the FIFO is empty.
  always_comb begin
    flit_out_type = 1'b0;
    flit_out_head = 1'b0;
    flit_out_tail = 1'b0;
    flit_out_data = '0;
    if (flit_out_valid) begin
      flit_out_type = head_entry[EW-1];
      flit_out_head = head_entry[EW-2];
      flit_out_tail = head_entry[EW-3];
      flit_out_data = head_entry[DATA_WIDTH-1:0];
    end
  end

`ifdef TNOC_FLIT_RECEIVER_CHECKER_EN
  typedef enum logic {IDLE = 1'b0, IN_PACKET = 1'b1} frame_state_e;

  frame_state_e state_q, state_d;
  logic         err_q, err_d;
  logic         bad;

  // Framing checker next-state. It advances once per accepted flit.
  // A head flit inside a packet starts a new packet.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    bad     = 1'b0;
    if (push) begin
      if (flit_in_head && flit_in_type) bad = 1'b1;
      if (state_q == IDLE) begin
        if (flit_in_head) state_d = flit_in_tail ? IDLE : IN_PACKET;
        else              bad     = 1'b1;
      end else begin
        if (flit_in_head) begin
          bad     = 1'b1;
          state_d = flit_in_tail ? IDLE : IN_PACKET;
        end else if (flit_in_tail) begin
          state_d = IDLE;
        end
      end
      err_d = err_q | bad;
    end
  end

  // Framing checker state and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign framing_error = err_q;
`else
  assign framing_error = 1'b0;
`endif

endmodule

// File: tb/tb_tnoc_flit_receiver.sv
// Testbench for tnoc_flit_receiver (DATA_WIDTH=64, DEPTH=4).
// The expected behaviour comes from a queue-based model of the packet stream.
module tb_tnoc_flit_receiver;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int EW    = DW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flit_in_valid = 1'b0;
  logic          flit_in_ready;
  logic          flit_in_type = 1'b0;
  logic          flit_in_head = 1'b0;
  logic          flit_in_tail = 1'b0;
  logic [DW-1:0] flit_in_data = '0;
  logic          flit_in_vc_available;
  logic          flit_out_valid;
  logic          flit_out_ready = 1'b0;
  logic          flit_out_type;
  logic          flit_out_head;
  logic          flit_out_tail;
  logic [DW-1:0] flit_out_data;
  logic [15:0]   packet_count;
  logic          framing_error;

  int checks   = 0;
  int failures = 0;

  // Reference model state. Each queue entry is {type, head, tail, data}.
  logic [EW-1:0] exp_q[$];
  logic [15:0]   exp_pkt = '0;
  logic          exp_err = 1'b0;
  logic          exp_vc  = 1'b0;
  logic          in_pkt  = 1'b0;

`ifdef TNOC_FLIT_RECEIVER_CHECKER_EN
  localparam bit CHECKER = 1'b1;
`else
  localparam bit CHECKER = 1'b0;
`endif

  tnoc_flit_receiver #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flit_in_valid        (flit_in_valid),
    .flit_in_ready        (flit_in_ready),
    .flit_in_type         (flit_in_type),
    .flit_in_head         (flit_in_head),
    .flit_in_tail         (flit_in_tail),
    .flit_in_data         (flit_in_data),
    .flit_in_vc_available (flit_in_vc_available),
    .flit_out_valid       (flit_out_valid),
    .flit_out_ready       (flit_out_ready),
    .flit_out_type        (flit_out_type),
    .flit_out_head        (flit_out_head),
    .flit_out_tail        (flit_out_tail),
    .flit_out_data        (flit_out_data),
    .packet_count         (packet_count),
    .framing_error        (framing_error)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the model's update for one rising edge.
  task automatic model_edge(input logic push, input logic pop, input logic [EW-1:0] f);
    logic ty, h, tl, bad;
    ty = f[EW-1]; h = f[EW-2]; tl = f[EW-3];
    if (pop)  void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(f);
      if (tl) exp_pkt = exp_pkt + 16'd1;
      bad = (h && ty) || (!in_pkt && !h) || (in_pkt && h);
      if (h)                in_pkt = !tl;
      else if (in_pkt && tl) in_pkt = 1'b0;
      if (CHECKER && bad) exp_err = 1'b1;
    end
    exp_vc = ((DEPTH - exp_q.size()) >= 2);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, DW'(flit_out_valid), DW'(exp_q.size() != 0));
    check({tag, ".in_ready"},  DW'(flit_in_ready),  DW'(exp_q.size() < DEPTH));
    check({tag, ".vc_avail"},  DW'(flit_in_vc_available), DW'(exp_vc));
    check({tag, ".pkt_cnt"},   DW'(packet_count), DW'(exp_pkt));
    check({tag, ".frame_err"}, DW'(framing_error), DW'(exp_err));
    if (exp_q.size() != 0) begin
      check({tag, ".out_flags"}, DW'({flit_out_type, flit_out_head, flit_out_tail}),
            DW'(exp_q[0][EW-1:EW-3]));
      check({tag, ".out_data"}, flit_out_data, exp_q[0][DW-1:0]);
    end
  endtask

  // Driver: one clock cycle. Called at posedge+1 and returns at the next posedge+1.
  task automatic cycle(input string tag, input logic v, input logic ty, input logic h,
                       input logic tl, input logic [DW-1:0] d, input logic ordy);
    logic push, pop;
    flit_in_valid  = v;
    flit_in_type   = ty;
    flit_in_head   = h;
    flit_in_tail   = tl;
    flit_in_data   = d;
    flit_out_ready = ordy;
    #2;
    check_outputs({tag, ".pre"});
    push = v && (exp_q.size() < DEPTH);
    pop  = ordy && (exp_q.size() != 0);
    @(posedge clk);
    model_edge(push, pop, {ty, h, tl, d});
    #1;
    check_outputs({tag, ".post"});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, DW'(flit_in_ready), '0);
    check({tag, ".vc"},    DW'(flit_in_vc_available), '0);
    check({tag, ".valid"}, DW'(flit_out_valid), '0);
    check({tag, ".pkt"},   DW'(packet_count), '0);
    check({tag, ".err"},   DW'(framing_error), '0);
    check({tag, ".flags"}, DW'({flit_out_type, flit_out_head, flit_out_tail}), '0);
    check({tag, ".data"},  flit_out_data, '0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pkt = '0;
    exp_err = 1'b0;
    exp_vc  = 1'b0;
    in_pkt  = 1'b0;
  endtask

  initial begin
    // Power-on reset.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single-flit packet: the flit is visible one edge after acceptance.
    cycle("single", 1'b1, 1'b0, 1'b1, 1'b1, 64'hA5, 1'b0);
    check("single.data_lit", flit_out_data, 64'hA5);
    check("single.pkt_lit", DW'(packet_count), 64'd1);
    cycle("single_pop", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Fill: five flits are offered with the output stalled, and four are accepted.
    // Flit 0 is a header and flits 1-4 are payloads of one packet.
    cycle("fill0", 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      cycle($sformatf("fill%0d", i), 1'b1, 1'b1, 1'b0, (i == 4), DW'(i), 1'b0);
      if (i == 3) check("fill.vc_after3", DW'(flit_in_vc_available), '0);
    end
    check("fill.ready_full", DW'(flit_in_ready), '0);
    check("fill.head_stable", flit_out_data, 64'd0);

    // Full with a simultaneous pop: there is no push this cycle, and flit 4 is pushed on the next cycle.
    cycle("fullpop", 1'b1, 1'b1, 1'b0, 1'b1, 64'd4, 1'b1);
    check("fullpop.ready_still0", DW'(flit_in_ready), DW'(exp_q.size() < DEPTH));
    cycle("fullpop_push", 1'b1, 1'b1, 1'b0, 1'b1, 64'd4, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("drain.empty", DW'(flit_out_valid), '0);

    // Streaming: a 3-flit packet is sent with valid and ready held high.
    cycle("stream0", 1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 1'b1);
    cycle("stream1", 1'b1, 1'b1, 1'b0, 1'b0, 64'h101, 1'b1);
    cycle("stream2", 1'b1, 1'b1, 1'b0, 1'b1, 64'h102, 1'b1);
    cycle("stream_drain", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Framing: a payload flit with head=0 arrives in IDLE. It is forwarded, and the error flag is sticky.
    cycle("frame_bad", 1'b1, 1'b1, 1'b0, 1'b1, 64'hBAD, 1'b0);
    check("frame_bad.err", DW'(framing_error), DW'(CHECKER));
    check("frame_bad.fwd", flit_out_data, 64'hBAD);
    cycle("frame_hold", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    cycle("frame_hold2", 1'b1, 1'b0, 1'b1, 1'b1, 64'h5, 1'b1);

    // Reset mid-packet: a header is accepted, then reset is pulsed asynchronously.
    cycle("mid_hdr", 1'b1, 1'b0, 1'b1, 1'b0, 64'h77, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    cycle("post_rst0", 1'b1, 1'b0, 1'b1, 1'b0, 64'h200, 1'b1);
    cycle("post_rst1", 1'b1, 1'b1, 1'b0, 1'b1, 64'h201, 1'b1);
    check("post_rst.err", DW'(framing_error), '0);
    cycle("post_rst_drain", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic, compared against the model.
    for (int i = 0; i < 300; i++) begin
      logic h, ty;
      h  = ($urandom_range(0, 2) == 0);
      ty = h ? ($urandom_range(0, 15) == 0) : 1'b1;
      cycle("rand", 1'(($urandom_range(0, 3) != 0)), ty, h, 1'(($urandom_range(0, 3) == 0)),
            {$urandom, $urandom}, 1'(($urandom_range(0, 2) != 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tnoc_flit_receiver.md
TNOC_FLIT_RECEIVER -- requirements
Module: tnoc_flit_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: flit data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: flit FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flit_in_valid, input, 1 bit: upstream flit valid.
REQ-006 SHALL have port flit_in_ready, output, 1 bit: receiver can accept a flit.
REQ-007 SHALL have port flit_in_type, input, 1 bit: 0 = header flit, 1 = payload flit.
REQ-008 SHALL have ports flit_in_head and flit_in_tail, inputs, 1 bit each: first and last flit of a packet.
REQ-009 SHALL have port flit_in_data, input, DATA_WIDTH bits: flit data.
REQ-010 SHALL have port flit_in_vc_available, output, 1 bit: upstream may start a new packet.
REQ-011 SHALL have port flit_out_valid, output, 1 bit, and port flit_out_ready, input, 1 bit: downstream handshake.
REQ-012 SHALL have ports flit_out_type, flit_out_head, flit_out_tail (1 bit each) and flit_out_data (DATA_WIDTH bits), outputs: head-of-FIFO flit.
REQ-013 SHALL have port packet_count, output, 16 bits: count of tail flits accepted.
REQ-014 SHALL have port framing_error, output, 1 bit: sticky protocol-violation flag.

Function
REQ-015 SHALL accept a flit on a rising edge where flit_in_valid and flit_in_ready are both 1, writing type, head, tail and data into the FIFO.
REQ-016 SHALL drive flit_in_ready = (occupancy < DEPTH), from registered state only; with the FIFO full and a same-cycle pop, ready stays 0.
REQ-017 SHALL present the FIFO head with first-word fall-through; flit_out_valid = (occupancy != 0).
REQ-018 SHALL pop one entry on an edge where flit_out_valid and flit_out_ready are both 1.
REQ-019 SHALL make a flit accepted at edge N visible on flit_out_* from edge N into an empty FIFO (one-cycle latency); stored data and order are unchanged.
REQ-020 SHALL, on a simultaneous push and pop, leave occupancy unchanged and preserve order; read and write pointers wrap modulo DEPTH.
REQ-021 SHALL hold flit_out_* stable while flit_out_valid=1 and flit_out_ready=0.
REQ-022 SHALL register flit_in_vc_available as 1 when post-update free entries >= 2, and 0 otherwise.
REQ-023 SHALL increment packet_count by 1 on each accepted flit with tail=1, wrapping from 0xFFFF to 0x0000.

Reset
REQ-024 SHALL, while rst=1, asynchronously clear the FIFO pointers and occupancy and set the framing FSM to IDLE.
REQ-025 SHALL, while rst=1, drive flit_in_ready=0, flit_in_vc_available=0, flit_out_valid=0, packet_count=0 and framing_error=0; flit_out_type, flit_out_head, flit_out_tail and flit_out_data read 0.
REQ-026 SHALL discard in-flight FIFO contents on reset mid-packet, and accept a new packet from the first edge after rst deasserts.

Configuration
REQ-027 SHALL compile the framing checker only when macro TNOC_FLIT_RECEIVER_CHECKER_EN is defined.
REQ-028 SHALL implement the checker as FSM states IDLE and IN_PACKET, evaluated per accepted flit.
- IDLE, head=1, tail=1 -> IDLE.
- IDLE, head=1, tail=0 -> IN_PACKET.
- IDLE, head=0 -> error; stay IDLE.
- IN_PACKET, head=1 -> error; treat the flit as a new packet start.
- IN_PACKET, tail=1 -> IDLE.
- Any flit with head=1 and type=1 -> error.
REQ-029 SHALL set framing_error on the edge that accepts the offending flit and hold it until reset; offending flits are still forwarded.
REQ-030 SHALL, without TNOC_FLIT_RECEIVER_CHECKER_EN, tie framing_error to 0 and omit the FSM; all other behaviour is identical.

Verification
REQ-031 SHALL cover single-flit packet (head=1, tail=1, type=0, data=0xA5) -> appears on flit_out one cycle later; packet_count=1; framing_error=0.
REQ-032 SHALL cover fill: DEPTH=4, flit_out_ready=0, 5 flits offered -> 4 accepted, flit_in_ready=0 after the 4th, flit_in_vc_available=0 after the 3rd.
REQ-033 SHALL cover full with simultaneous pop: flit_out_ready=1 while full -> one pop, no push that cycle, push next cycle; order 0,1,2,3,4 preserved.
REQ-034 SHALL cover streaming: 3-flit packet with valid and ready held high -> one flit per cycle, ready never drops, packet_count increments on the tail only.
REQ-035 SHALL cover the checker (macro defined): payload flit with head=0 in IDLE -> framing_error=1 next edge, flit forwarded, flag held; macro undefined -> framing_error stays 0.
REQ-036 SHALL cover reset mid-packet: header accepted, rst pulsed -> flit_out_valid=0, packet_count=0, and the next packet is accepted without error.
